// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file: read, write and issue ports.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_a_idx;
  logic [ADDR_W-1:0] rd_b_idx;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic [DATA_W-1:0] rd_sp_data;
  logic              rd_a_busy;
  logic              rd_b_busy;
  logic              wr_e_en;
  logic [ADDR_W-1:0] wr_e_idx;
  logic [DATA_W-1:0] wr_e_data;
  logic              wr_m_en;
  logic [ADDR_W-1:0] wr_m_idx;
  logic [DATA_W-1:0] wr_m_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_idx;
  logic              any_busy;

  modport master (
    output rd_a_idx, rd_b_idx, wr_e_en, wr_e_idx, wr_e_data,
    output wr_m_en, wr_m_idx, wr_m_data, iss_en, iss_idx,
    input  rd_a_data, rd_b_data, rd_sp_data, rd_a_busy, rd_b_busy, any_busy
  );

  modport slave (
    input  rd_a_idx, rd_b_idx, wr_e_en, wr_e_idx, wr_e_data,
    input  wr_m_en, wr_m_idx, wr_m_data, iss_en, iss_idx,
    output rd_a_data, rd_b_data, rd_sp_data, rd_a_busy, rd_b_busy, any_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Y86-64 register file: two read ports plus %rsp port, E/M write ports, optional write bypass,
// and a per-register pending scoreboard set at issue and cleared at writeback.
module regfile_sb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREG   = 15,
  parameter int unsigned SP_IDX = 4,
  parameter int unsigned BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave rf
);

  localparam logic [ADDR_W:0]   NRegW = (ADDR_W + 1)'(NREG);
  localparam logic [ADDR_W-1:0] SpIdx = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pending_q, pending_d;

  logic              e_ok, m_ok;
  logic [ADDR_W-1:0] rd_idx [3];
  logic [DATA_W-1:0] rd_val [3];

  assign e_ok = rf.wr_e_en && ({1'b0, rf.wr_e_idx} < NRegW);
  assign m_ok = rf.wr_m_en && ({1'b0, rf.wr_m_idx} < NRegW);

  assign rd_idx[0] = rf.rd_a_idx;
  assign rd_idx[1] = rf.rd_b_idx;
  assign rd_idx[2] = SpIdx;

  // Unmatched indices fall through to zero; M is applied last so it wins the bypass.
  // Bypass is suppressed while in reset so reads stay at zero.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_val[p] = '0;
      for (int i = 0; i < NREG; i++) begin
        if (rd_idx[p] == ADDR_W'(i)) rd_val[p] = regs_q[i];
      end
      if (BYPASS != 0 && !rst) begin
        if (e_ok && rd_idx[p] == rf.wr_e_idx) rd_val[p] = rf.wr_e_data;
        if (m_ok && rd_idx[p] == rf.wr_m_idx) rd_val[p] = rf.wr_m_data;
      end
    end
  end

  assign rf.rd_a_data  = rd_val[0];
  assign rf.rd_b_data  = rd_val[1];
  assign rf.rd_sp_data = rd_val[2];

  // Busy reports the stored bit only, so a same-cycle clear still stalls.
  always_comb begin
    rf.rd_a_busy = 1'b0;
    rf.rd_b_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rf.rd_a_idx == ADDR_W'(i)) rf.rd_a_busy = pending_q[i];
      if (rf.rd_b_idx == ADDR_W'(i)) rf.rd_b_busy = pending_q[i];
    end
  end

  assign rf.any_busy = |pending_q;

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int i = 0; i < NREG; i++) begin
      if (rf.wr_e_en && rf.wr_e_idx == ADDR_W'(i)) regs_d[i] = rf.wr_e_data;
      if (rf.wr_m_en && rf.wr_m_idx == ADDR_W'(i)) regs_d[i] = rf.wr_m_data;
      if ((rf.wr_e_en && rf.wr_e_idx == ADDR_W'(i)) ||
          (rf.wr_m_en && rf.wr_m_idx == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (rf.iss_en && rf.iss_idx == ADDR_W'(i)) pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Drives one stimulus stream into a BYPASS=0 and a BYPASS=1 instance and checks both
// against an array-based reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  rd_a_idx, rd_b_idx, wr_e_idx, wr_m_idx, iss_idx;
  logic [63:0] wr_e_data, wr_m_data;
  logic        wr_e_en, wr_m_en, iss_en;

  regfile_sb_if #(.DATA_W(64), .ADDR_W(4)) if0 ();
  regfile_sb_if #(.DATA_W(64), .ADDR_W(4)) if1 ();

  assign if0.rd_a_idx = rd_a_idx;   assign if1.rd_a_idx = rd_a_idx;
  assign if0.rd_b_idx = rd_b_idx;   assign if1.rd_b_idx = rd_b_idx;
  assign if0.wr_e_en = wr_e_en;     assign if1.wr_e_en = wr_e_en;
  assign if0.wr_e_idx = wr_e_idx;   assign if1.wr_e_idx = wr_e_idx;
  assign if0.wr_e_data = wr_e_data; assign if1.wr_e_data = wr_e_data;
  assign if0.wr_m_en = wr_m_en;     assign if1.wr_m_en = wr_m_en;
  assign if0.wr_m_idx = wr_m_idx;   assign if1.wr_m_idx = wr_m_idx;
  assign if0.wr_m_data = wr_m_data; assign if1.wr_m_data = wr_m_data;
  assign if0.iss_en = iss_en;       assign if1.iss_en = iss_en;
  assign if0.iss_idx = iss_idx;     assign if1.iss_idx = iss_idx;

  regfile_sb #(.DATA_W(64), .ADDR_W(4), .NREG(15), .SP_IDX(4), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rf(if0)
  );
  regfile_sb #(.DATA_W(64), .ADDR_W(4), .NREG(15), .SP_IDX(4), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .rf(if1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mreg  [15];
  bit          mpend [15];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit valid(input logic [3:0] idx);
    return int'(idx) < 15;
  endfunction

  // Expected read value for a BYPASS=byp instance given the current inputs.
  function automatic logic [63:0] exp_rd(input logic [3:0] idx, input bit byp);
    if (rst || !valid(idx)) return 64'd0;
    if (byp && wr_m_en && valid(wr_m_idx) && wr_m_idx == idx) return wr_m_data;
    if (byp && wr_e_en && valid(wr_e_idx) && wr_e_idx == idx) return wr_e_data;
    return mreg[int'(idx)];
  endfunction

  function automatic logic [63:0] exp_busy(input logic [3:0] idx);
    if (!valid(idx)) return 64'd0;
    return {63'd0, mpend[int'(idx)]};
  endfunction

  function automatic logic [63:0] exp_any();
    for (int i = 0; i < 15; i++) if (mpend[i]) return 64'd1;
    return 64'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) begin
      mreg[i]  = 64'd0;
      mpend[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    if (wr_e_en && valid(wr_e_idx)) begin
      mreg[int'(wr_e_idx)]  = wr_e_data;
      mpend[int'(wr_e_idx)] = 1'b0;
    end
    if (wr_m_en && valid(wr_m_idx)) begin
      mreg[int'(wr_m_idx)]  = wr_m_data;
      mpend[int'(wr_m_idx)] = 1'b0;
    end
    if (iss_en && valid(iss_idx)) mpend[int'(iss_idx)] = 1'b1;
  endtask

  task automatic compare_all(input string ph);
    chk({ph, " d0 rd_a_data"}, if0.rd_a_data, exp_rd(rd_a_idx, 1'b0));
    chk({ph, " d0 rd_b_data"}, if0.rd_b_data, exp_rd(rd_b_idx, 1'b0));
    chk({ph, " d0 rd_sp_data"}, if0.rd_sp_data, exp_rd(4'd4, 1'b0));
    chk({ph, " d1 rd_a_data"}, if1.rd_a_data, exp_rd(rd_a_idx, 1'b1));
    chk({ph, " d1 rd_b_data"}, if1.rd_b_data, exp_rd(rd_b_idx, 1'b1));
    chk({ph, " d1 rd_sp_data"}, if1.rd_sp_data, exp_rd(4'd4, 1'b1));
    chk({ph, " d0 rd_a_busy"}, {63'd0, if0.rd_a_busy}, exp_busy(rd_a_idx));
    chk({ph, " d0 rd_b_busy"}, {63'd0, if0.rd_b_busy}, exp_busy(rd_b_idx));
    chk({ph, " d1 rd_a_busy"}, {63'd0, if1.rd_a_busy}, exp_busy(rd_a_idx));
    chk({ph, " d1 rd_b_busy"}, {63'd0, if1.rd_b_busy}, exp_busy(rd_b_idx));
    chk({ph, " d0 any_busy"}, {63'd0, if0.any_busy}, exp_any());
    chk({ph, " d1 any_busy"}, {63'd0, if1.any_busy}, exp_any());
  endtask

  // Inputs are set at posedge+1; check at +3, then clock the model on the edge.
  task automatic step(input string ph);
    #2;
    compare_all(ph);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    wr_e_en = 1'b0; wr_m_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic wr_e(input logic [3:0] idx, input logic [63:0] d);
    wr_e_en = 1'b1; wr_e_idx = idx; wr_e_data = d;
  endtask

  task automatic wr_m(input logic [3:0] idx, input logic [63:0] d);
    wr_m_en = 1'b1; wr_m_idx = idx; wr_m_data = d;
  endtask

  task automatic issue(input logic [3:0] idx);
    iss_en = 1'b1; iss_idx = idx;
  endtask

  initial begin
    rst = 1'b1;
    rd_a_idx = 4'd0; rd_b_idx = 4'd0;
    wr_e_idx = 4'd0; wr_m_idx = 4'd0; iss_idx = 4'd0;
    wr_e_data = 64'd0; wr_m_data = 64'd0;
    idle();
    model_reset();
    #3;
    compare_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Asynchronous reset mid-cycle after writes and an issue.
    wr_e(4'd5, 64'h0123_4567_89AB_CDEF); issue(4'd6);
    step("pre_rst");
    idle(); wr_m(4'd4, 64'h5555_AAAA_5555_AAAA); issue(4'd5);
    rd_a_idx = 4'd5; rd_b_idx = 4'd6;
    step("pre_rst2");
    wr_e(4'd5, 64'hFFFF_0000_FFFF_0000); issue(4'd6);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("async_rst");
    @(posedge clk); #1;
    compare_all("rst_edge");
    rst = 1'b0;
    idle();
    step("post_rst");

    // Write then read with 1-cycle latency; bypass instance sees it at once.
    rd_a_idx = 4'd3; rd_b_idx = 4'd0;
    wr_e(4'd3, 64'h1122_3344_5566_7788);
    step("wr3");
    idle();
    step("rd3");

    // Dual write to %rsp: M wins.
    rd_a_idx = 4'd4;
    wr_e(4'd4, 64'hAAAA); wr_m(4'd4, 64'hBBBB);
    step("dual4");
    idle();
    step("dual4_after");

    // RNONE is inert for writes, issues and reads.
    rd_a_idx = 4'hF; rd_b_idx = 4'hF;
    wr_m(4'hF, 64'hDEAD); issue(4'hF);
    step("rnone");
    idle();
    step("rnone_after");

    // Scoreboard timing.
    rd_b_idx = 4'd2; rd_a_idx = 4'd3;
    issue(4'd2);
    step("sb_n");
    idle();
    step("sb_n1");
    step("sb_n2");
    wr_e(4'd2, 64'h2222);
    step("sb_n3");
    idle();
    step("sb_n4");
    issue(4'd2); wr_e(4'd2, 64'h3333);
    step("sb_setwin");
    idle();
    step("sb_setwin_after");
    wr_m(4'd2, 64'h4444);
    step("sb_clr_m");
    idle();

    // Full sweep, read back on both ports.
    for (int i = 0; i < 15; i++) begin
      wr_e(4'(i), 64'h0101_0101_0101_0101 * 64'(i));
      step("sweep_wr");
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      rd_a_idx = 4'(i); rd_b_idx = 4'(15 - i);
      step("sweep_rd");
    end

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      rd_a_idx  = 4'($urandom_range(0, 15));
      rd_b_idx  = 4'($urandom_range(0, 15));
      wr_e_en   = 1'($urandom);
      wr_e_idx  = 4'($urandom_range(0, 15));
      wr_e_data = {$urandom, $urandom};
      wr_m_en   = 1'($urandom);
      wr_m_idx  = ($urandom_range(0, 3) == 0) ? wr_e_idx : 4'($urandom_range(0, 15));
      wr_m_data = {$urandom, $urandom};
      iss_en    = 1'($urandom);
      iss_idx   = ($urandom_range(0, 3) == 0) ? wr_e_idx : 4'($urandom_range(0, 15));
      step("rand");
    end
    idle();
    step("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
